// File: rtl/ethernet_pkg.sv
// ============================================================================
// ethernet_pkg: shared descriptor type and default depths for the TX buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ethernet_pkg;

  localparam int ETH_TX_DATA_DEPTH = 2048;
  localparam int ETH_TX_DESC_DEPTH = 8;

  typedef struct packed {
    logic [5:0][7:0] dest_address;
    logic [1:0][7:0] payload_length;
  } ethernet_tx_descriptor_t;

  localparam int ETH_TX_DESC_W = $bits(ethernet_tx_descriptor_t);

endpackage

`default_nettype wire

// File: rtl/ethernet_tx_fifo.sv
// ============================================================================
// ethernet_tx_fifo: wrap-bit pointer FIFO with registered (non show-ahead)
// pop output and a write-pointer rewind hook. Revision: 1.0
// ============================================================================
`default_nettype none

module ethernet_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     rewind_i,
  input  logic [$clog2(DEPTH):0]   rewind_ptr_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   wr_ptr_o,
  output logic [$clog2(DEPTH):0]   rd_ptr_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             push_ok, pop_ok;

  // Flags come from the current pointers, so a same-cycle pop never frees room for a push.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o && !rewind_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop_data_d = pop_data_q;
    if (rewind_i) begin
      wr_ptr_d = rewind_ptr_i;
    end else if (push_ok) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      pop_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pop_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pop_data_q <= pop_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign pop_data_o = pop_data_q;
  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/ethernet_tx_buffer.sv
// ============================================================================
// ethernet_tx_buffer: byte + descriptor staging queues for the Ethernet TX.
// Option macro ETH_TX_BUFFER_ABORT_EN adds abort_i (drop uncommitted bytes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ethernet_tx_buffer
  import ethernet_pkg::*;
#(
  parameter int DATA_DEPTH = ETH_TX_DATA_DEPTH,
  parameter int DESC_DEPTH = ETH_TX_DESC_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
`ifdef ETH_TX_BUFFER_ABORT_EN
  input  logic                         abort_i,
`endif
  input  logic                         write_data_i,
  input  logic [7:0]                   wr_data_i,
  input  logic                         commit_i,
  input  logic [5:0][7:0]              dest_address_i,
  input  logic [1:0][7:0]              payload_length_i,
  output logic                         data_ready_o,
  input  logic                         read_descriptor_i,
  output logic [5:0][7:0]              dest_address_o,
  output logic [1:0][7:0]              payload_length_o,
  input  logic                         read_data_i,
  output logic [7:0]                   payload_data_o,
  output logic                         data_full_o,
  output logic                         desc_full_o,
  output logic [$clog2(DATA_DEPTH):0]  data_free_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  input  logic                         clear_error_i
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int QAW = $clog2(DESC_DEPTH);

  logic                   data_full, data_empty, desc_full, desc_empty;
  logic [DAW:0]           data_wr_ptr, data_rd_ptr;
  logic [QAW:0]           desc_wr_ptr, desc_rd_ptr;
  logic [DAW:0]           commit_ptr_q, commit_ptr_d;
  logic                   overflow_q, overflow_d, underflow_q, underflow_d;
  logic                   abort_eff, byte_push, commit_ok;
  logic                   overflow_evt, underflow_evt;
  ethernet_tx_descriptor_t desc_in, desc_out;
  logic                   unused_ptrs;

`ifdef ETH_TX_BUFFER_ABORT_EN
  // A coincident commit closes the frame instead of discarding it.
  assign abort_eff = abort_i && !commit_i;
`else
  assign abort_eff = 1'b0;
`endif

  assign byte_push = write_data_i && !abort_eff;
  assign commit_ok = commit_i && !desc_full;

  assign desc_in.dest_address   = dest_address_i;
  assign desc_in.payload_length = payload_length_i;

  ethernet_tx_fifo #(
    .WIDTH (8),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (byte_push),
    .push_data_i  (wr_data_i),
    .pop_i        (read_data_i),
    .rewind_i     (abort_eff),
    .rewind_ptr_i (commit_ptr_q),
    .pop_data_o   (payload_data_o),
    .full_o       (data_full),
    .empty_o      (data_empty),
    .wr_ptr_o     (data_wr_ptr),
    .rd_ptr_o     (data_rd_ptr)
  );

  ethernet_tx_fifo #(
    .WIDTH (ETH_TX_DESC_W),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (commit_i),
    .push_data_i  (desc_in),
    .pop_i        (read_descriptor_i),
    .rewind_i     (1'b0),
    .rewind_ptr_i ('0),
    .pop_data_o   (desc_out),
    .full_o       (desc_full),
    .empty_o      (desc_empty),
    .wr_ptr_o     (desc_wr_ptr),
    .rd_ptr_o     (desc_rd_ptr)
  );

  assign overflow_evt  = (byte_push && data_full) || (commit_i && desc_full);
  assign underflow_evt = (read_data_i && data_empty) || (read_descriptor_i && desc_empty);

  always_comb begin
    commit_ptr_d = commit_ok ? data_wr_ptr : commit_ptr_q;
    // A new error in the clearing cycle keeps the flag set.
    overflow_d   = (overflow_q  && !clear_error_i) || overflow_evt;
    underflow_d  = (underflow_q && !clear_error_i) || underflow_evt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_ptr_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      commit_ptr_q <= commit_ptr_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // The descriptor queue pointers only feed its own flags; commit_ptr is read only by abort.
`ifdef ETH_TX_BUFFER_ABORT_EN
  assign unused_ptrs = ^{desc_wr_ptr, desc_rd_ptr};
`else
  assign unused_ptrs = ^{desc_wr_ptr, desc_rd_ptr, commit_ptr_q};
`endif

  assign data_ready_o     = !desc_empty;
  assign data_full_o      = data_full;
  assign desc_full_o      = desc_full;
  assign data_free_o      = (DAW+1)'(DATA_DEPTH) - (data_wr_ptr - data_rd_ptr);
  assign dest_address_o   = desc_out.dest_address;
  assign payload_length_o = desc_out.payload_length;
  assign overflow_o       = overflow_q;
  assign underflow_o      = underflow_q;

endmodule

`default_nettype wire
